// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. Two sources share one write port: the in-order pipeline (P)
// and the multi-cycle unit (M). A pending-result scoreboard lets decode detect RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic [AW-1:0]   p_addr,
    input  logic [XLEN-1:0] p_data,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [AW-1:0]   m_addr,
    input  logic [XLEN-1:0] m_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_addr,
    output logic            issue_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_cnt,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic [3:0]      starve_cnt;
    logic            p_elig;
    logic            m_elig;
    logic            grant_p;
    logic            grant_m;
    logic            issue_fire;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    assign issue_ready = !busy[issue_addr];
    assign issue_fire  = issue_valid && issue_ready;
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];

    // A P write to a register still owed by M would be overwritten out of order, so P waits.
    assign p_elig  = p_valid && !busy[p_addr];
    assign m_elig  = m_valid;
    assign grant_m = m_elig && (!p_elig || (starve_cnt == STARVE_LIM));
    assign grant_p = p_elig && !grant_m;
    assign p_ready = grant_p;
    assign m_ready = grant_m;

    assign win_addr = grant_m ? m_addr : p_addr;
    assign win_data = grant_m ? m_data : p_data;

    // Set after clear, so an issue to a register M writes in the same cycle stays pending.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        if (grant_m) busy_nxt[m_addr] = 1'b0;
        if (issue_fire) busy_nxt[issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
            starve_cnt  <= '0;
            rf_wen      <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
            if (grant_m) begin
                starve_cnt <= '0;
            end else if (m_elig && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            rf_wen <= (grant_p || grant_m) && (win_addr != '0);
            if ((grant_p || grant_m) && (win_addr != '0)) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with default parameters.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_valid;
    logic        p_ready;
    logic [4:0]  p_addr;
    logic [63:0] p_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [5:0]  pending_cnt;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int checks = 0;
    int fails  = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .pending_cnt(pending_cnt), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [63:0] pd,
                                 input logic mv, input logic [4:0] ma, input logic [63:0] md,
                                 input logic iv, input logic [4:0] ia);
        p_valid     = pv;
        p_addr      = pa;
        p_data      = pd;
        m_valid     = mv;
        m_addr      = ma;
        m_data      = md;
        issue_valid = iv;
        issue_addr  = ia;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        checkOutput("reset_rf_wen", 64'(rf_wen), 0);
        checkOutput("reset_rf_waddr", 64'(rf_waddr), 0);
        checkOutput("reset_rf_wdata", rf_wdata, 0);
        checkOutput("reset_pending", 64'(pending_cnt), 0);
        checkOutput("reset_issue_ready", 64'(issue_ready), 1);
        #10;
        rst_n = 1'b1;
        tick();

        // P-only write
        applyStimulus(1, 3, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
        checkOutput("p_only_p_ready", 64'(p_ready), 1);
        checkOutput("p_only_m_ready", 64'(m_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("p_only_rf_wen", 64'(rf_wen), 1);
        checkOutput("p_only_rf_waddr", 64'(rf_waddr), 3);
        checkOutput("p_only_rf_wdata", rf_wdata, 64'hDEAD_BEEF);
        tick();
        checkOutput("p_only_wen_drop", 64'(rf_wen), 0);
        checkOutput("p_only_waddr_hold", 64'(rf_waddr), 3);

        // Issue x7 then M writes it back
        rs1_addr = 7;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        checkOutput("issue7_ready", 64'(issue_ready), 1);
        checkOutput("issue7_rs1_before", 64'(rs1_busy), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("issue7_pending", 64'(pending_cnt), 1);
        checkOutput("issue7_rs1_busy", 64'(rs1_busy), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        checkOutput("issue7_again_ready", 64'(issue_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 64'h1234, 0, 0);
        checkOutput("issue7_pending_hold", 64'(pending_cnt), 1);
        checkOutput("m7_m_ready", 64'(m_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("m7_rf_wen", 64'(rf_wen), 1);
        checkOutput("m7_rf_waddr", 64'(rf_waddr), 7);
        checkOutput("m7_rf_wdata", rf_wdata, 64'h1234);
        checkOutput("m7_pending", 64'(pending_cnt), 0);
        checkOutput("m7_rs1_busy", 64'(rs1_busy), 0);

        // Starvation: both valid continuously -> P x4, M x1, repeating
        applyStimulus(1, 1, 64'h11, 1, 2, 64'h22, 0, 0);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("starve_p_ready_%0d", k), 64'(p_ready), 64'((k % 5) != 4));
            checkOutput($sformatf("starve_m_ready_%0d", k), 64'(m_ready), 64'((k % 5) == 4));
            tick();
            checkOutput($sformatf("starve_waddr_%0d", k), 64'(rf_waddr), ((k % 5) == 4) ? 2 : 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // WAW hold on x9
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        applyStimulus(1, 9, 64'hAAAA, 0, 0, 0, 0, 0);
        checkOutput("waw_p_held_0", 64'(p_ready), 0);
        tick();
        checkOutput("waw_p_held_1", 64'(p_ready), 0);
        applyStimulus(1, 9, 64'hAAAA, 1, 9, 64'hBBBB, 0, 0);
        checkOutput("waw_m_ready", 64'(m_ready), 1);
        checkOutput("waw_p_held_2", 64'(p_ready), 0);
        tick();
        applyStimulus(1, 9, 64'hAAAA, 0, 0, 0, 0, 0);
        checkOutput("waw_p_ready_after", 64'(p_ready), 1);
        checkOutput("waw_rf_m_wdata", rf_wdata, 64'hBBBB);
        checkOutput("waw_rf_m_wen", 64'(rf_wen), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("waw_rf_p_wdata", rf_wdata, 64'hAAAA);
        checkOutput("waw_rf_p_waddr", 64'(rf_waddr), 9);
        checkOutput("waw_rf_p_wen", 64'(rf_wen), 1);

        // x0 handling alongside an issue to x5
        applyStimulus(1, 0, 64'h5555, 0, 0, 0, 1, 5);
        checkOutput("x0_p_ready", 64'(p_ready), 1);
        tick();
        rs1_addr = 0;
        applyStimulus(1, 4, 64'h44, 0, 0, 0, 1, 0);
        checkOutput("x0_rf_wen", 64'(rf_wen), 0);
        checkOutput("x0_pending_x5", 64'(pending_cnt), 1);
        checkOutput("x0_issue_ready", 64'(issue_ready), 1);
        checkOutput("x0_rs1_busy", 64'(rs1_busy), 0);
        tick();
        checkOutput("x0_pending_unchanged", 64'(pending_cnt), 1);
        checkOutput("x0_p4_wen", 64'(rf_wen), 1);

        // Reset mid-operation
        rs1_addr = 5;
        applyStimulus(0, 0, 0, 1, 5, 64'h55, 0, 0);
        checkOutput("rst_pre_rs1_busy", 64'(rs1_busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rf_wen", 64'(rf_wen), 0);
        checkOutput("rst_mid_rf_waddr", 64'(rf_waddr), 0);
        checkOutput("rst_mid_rs1_busy", 64'(rs1_busy), 0);
        checkOutput("rst_mid_pending", 64'(pending_cnt), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_post_rf_wen", 64'(rf_wen), 0);
        checkOutput("rst_post_pending", 64'(pending_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
